// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and defaults for the two-source udp_tx arbiter.
package udp_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int unsigned IFG_CYCLES_DEF     = 12;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie, the source not served last wins.
module rr_arb2
  import udp_tx_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    gnt = 2'b00;
    idx = 1'b0;
    case (req)
      2'b01: begin
        gnt = 2'b01;
        idx = 1'b0;
      end
      2'b10: begin
        gnt = 2'b10;
        idx = 1'b1;
      end
      2'b11: begin
        idx = ~last;
        gnt = onehot2(~last);
      end
      default: begin
        gnt = 2'b00;
        idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares one udp_tx engine between two frame sources with an inter-frame gap.
// Define UDP_ARB_TIMEOUT_EN to enable the WAIT_DONE watchdog.
module udp_tx_arbiter
  import udp_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned IFG_CYCLES     = IFG_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [16*NUM_SRC-1:0] src_byte_num,
  input  logic [8*NUM_SRC-1:0]  src_data,
  output logic [NUM_SRC-1:0]    src_grant,
  output logic [NUM_SRC-1:0]    src_rd_en,
  output logic [NUM_SRC-1:0]    src_done,
  output logic                  tx_start_en,
  output logic [15:0]           tx_byte_num,
  output logic [7:0]            tx_data,
  input  logic                  tx_req,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  timeout_err
);

`ifdef UDP_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [7:0]  GAP_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        gidx_q, gidx_d;
  logic [15:0] bytes_q, bytes_d;
  logic        start_q, start_d;
  logic [1:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] to_q, to_d;
  logic        terr_q, terr_d;

  logic [1:0]  pick_gnt;
  logic        pick_idx;
  logic [15:0] pick_bytes;

  rr_arb2 u_rr (
    .req  (src_req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign pick_bytes = pick_idx ? src_byte_num[31:16]
                               : src_byte_num[15:0];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    bytes_d = bytes_q;
    start_d = 1'b0;
    done_d  = 2'b00;
    last_d  = last_q;
    gap_d   = gap_q;
    to_d    = to_q;
    terr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|src_req) begin
          state_d = START;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          bytes_d = pick_bytes;
          start_d = (pick_bytes != 16'd0);
        end
      end
      START: begin
        // empty frame: complete it without ever starting udp_tx
        if (bytes_q == 16'd0) begin
          done_d  = grant_q;
          grant_d = 2'b00;
          last_d  = gidx_q;
          gap_d   = 8'd0;
          state_d = GAP;
        end else begin
          to_d    = 16'd0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          done_d  = grant_q;
          grant_d = 2'b00;
          last_d  = gidx_q;
          gap_d   = 8'd0;
          state_d = GAP;
        end else if (TO_EN && to_q == TO_LAST) begin
          terr_d  = 1'b1;
          grant_d = 2'b00;
          last_d  = gidx_q;
          gap_d   = 8'd0;
          state_d = GAP;
        end else if (TO_EN) begin
          to_d = to_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 8'd0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      gidx_q  <= 1'b0;
      bytes_q <= 16'd0;
      start_q <= 1'b0;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      gap_q   <= 8'd0;
      to_q    <= 16'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      bytes_q <= bytes_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (grant_q[0]) begin
      tx_data = src_data[7:0];
    end else if (grant_q[1]) begin
      tx_data = src_data[15:8];
    end
  end

  assign src_rd_en   = (state_q == WAIT_DONE) ? (grant_q & {2{tx_req}})
                                              : 2'b00;
  assign src_grant   = grant_q;
  assign src_done    = done_q;
  assign tx_start_en = start_q;
  assign tx_byte_num = bytes_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed + randomized bench for udp_tx_arbiter with a frame-level model.
// Build with UDP_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_udp_tx_arbiter;

  localparam int IFG = 12;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_req;
  logic [31:0] src_byte_num;
  logic [15:0] src_data;
  logic [1:0]  src_grant;
  logic [1:0]  src_rd_en;
  logic [1:0]  src_done;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_done;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_start = -1;
  bit m_last = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_tx_arbiter #(
    .NUM_SRC        (2),
    .IFG_CYCLES     (IFG),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_req      (src_req),
    .src_byte_num (src_byte_num),
    .src_data     (src_data),
    .src_grant    (src_grant),
    .src_rd_en    (src_rd_en),
    .src_done     (src_done),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_data      (tx_data),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(src_grant), 0);
    chk({tag, "_rd_en"}, 32'(src_rd_en), 0);
    chk({tag, "_done"}, 32'(src_done), 0);
    chk({tag, "_start"}, 32'(tx_start_en), 0);
    chk({tag, "_bytes"}, 32'(tx_byte_num), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_terr"}, 32'(timeout_err), 0);
  endtask

  // Called on the negedge of an IDLE cycle; returns on the next IDLE negedge.
  task automatic frame(input logic [1:0] req,
                       input logic [15:0] b0,
                       input logic [15:0] b1,
                       input int dly,
                       input bit hold,
                       input bit to_mode);
    bit g;
    logic [1:0] gv;
    logic [15:0] eb;
    g  = (req == 2'b11) ? ~m_last : req[1];
    gv = g ? 2'b10 : 2'b01;
    eb = g ? b1 : b0;
    chk("idle_busy", 32'(busy), 0);
    src_req = req;
    src_byte_num = {b1, b0};
    @(negedge clk);
    chk("start_grant", 32'(src_grant), 32'(gv));
    chk("start_bytes", 32'(tx_byte_num), 32'(eb));
    chk("start_en", 32'(tx_start_en), 32'(eb != 0));
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(src_done), 0);
    if (eb != 0) begin
      if (last_start >= 0)
        chk("start_spacing", 32'(cyc - last_start >= IFG + 2), 1);
      last_start = cyc;
    end
    if (!hold) src_req = 2'b00;
    if (eb != 0) begin
      for (int k = 1; k <= dly; k++) begin
        @(negedge clk);
        tx_req = 1'($urandom_range(0, 1));
        src_data = 16'($urandom);
        if (k == dly && !to_mode) tx_done = 1'b1;
        #1;
        chk("wd_grant", 32'(src_grant), 32'(gv));
        chk("wd_rd_en", 32'(src_rd_en), 32'(gv & {2{tx_req}}));
        chk("wd_data", 32'(tx_data),
            32'(g ? src_data[15:8] : src_data[7:0]));
        chk("wd_start", 32'(tx_start_en), 0);
        chk("wd_done", 32'(src_done), 0);
        chk("wd_terr", 32'(timeout_err), 0);
      end
    end
    @(negedge clk);
    tx_done = 1'b0;
    tx_req = 1'b0;
    chk("gap_done", 32'(src_done), to_mode ? 0 : 32'(gv));
    chk("gap_terr", 32'(timeout_err), 32'(to_mode));
    chk("gap_grant", 32'(src_grant), 0);
    chk("gap_busy", 32'(busy), 1);
    m_last = g;
    for (int i = 2; i <= IFG; i++) begin
      tx_done = 1'($urandom_range(0, 1));
      tx_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("gap_busy", 32'(busy), 1);
      chk("gap_done2", 32'(src_done), 0);
      chk("gap_start", 32'(tx_start_en), 0);
      chk("gap_grant", 32'(src_grant), 0);
      chk("gap_rd_en", 32'(src_rd_en), 0);
    end
    tx_done = 1'b0;
    tx_req = 1'b0;
    @(negedge clk);
    chk("end_busy", 32'(busy), 0);
    chk("end_grant", 32'(src_grant), 0);
  endtask

  initial begin
    logic [1:0] rq;
    logic [15:0] rb0, rb1;
    int stuck_n;
    rst = 1'b1;
    src_req = 2'b00;
    src_byte_num = 32'd0;
    src_data = 16'd0;
    tx_req = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);

    // simultaneous requests from reset, held for four frames
    frame(2'b11, 16'd100, 16'd200, 5, 1'b1, 1'b0);
    frame(2'b11, 16'd101, 16'd201, 3, 1'b1, 1'b0);
    frame(2'b11, 16'd102, 16'd202, 1, 1'b1, 1'b0);
    frame(2'b11, 16'd103, 16'd203, 7, 1'b0, 1'b0);

    // single source, long frame
    frame(2'b01, 16'd1024, 16'd7, 1030, 1'b0, 1'b0);

    // empty frame on source 1
    frame(2'b10, 16'd5, 16'd0, 0, 1'b0, 1'b0);

    // read-enable routing while source 1 holds the grant
    frame(2'b10, 16'd3, 16'd40, 20, 1'b0, 1'b0);

    // tx_done while idle must be ignored
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("idle_txdone_busy", 32'(busy), 0);
    chk("idle_txdone_done", 32'(src_done), 0);

    repeat (25) begin
      rq  = 2'($urandom_range(1, 3));
      rb0 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      rb1 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      frame(rq, rb0, rb1, $urandom_range(1, 20),
            1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef UDP_ARB_TIMEOUT_EN
    frame(2'b11, 16'd9, 16'd9, TO, 1'b1, 1'b1);
    frame(2'b11, 16'd9, 16'd9, 3, 1'b0, 1'b0);
    stuck_n = 50;
`else
    stuck_n = 300;
`endif

    // frame that never completes, then reset in the middle of it
    src_req = 2'b10;
    src_byte_num = {16'd50, 16'd60};
    @(negedge clk);
    src_req = 2'b00;
    chk("stuck_start", 32'(src_grant), 32'(2'b10));
    for (int i = 0; i < stuck_n; i++) begin
      tx_req = 1'b1;
      @(negedge clk);
      chk("stuck_busy", 32'(busy), 1);
      chk("stuck_grant", 32'(src_grant), 32'(2'b10));
      chk("stuck_terr", 32'(timeout_err), 0);
    end
    chk("stuck_rd_en", 32'(src_rd_en), 32'(2'b10));
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_done", 32'(src_done), 0);
    end
    tx_req = 1'b0;
    rst = 1'b0;
    m_last = 1'b1;
    last_start = -1;
    frame(2'b11, 16'd30, 16'd40, 4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
